reg_file: RTL and testbench

Integer register file for the hxd32 RV32I core: 32 general-purpose registers of XLEN bits each. It has two combinational read ports (rs1, rs2) and one synchronous write port (rd). Register x0 is hardwired to zero. The decode stage reads operands from it, and the write-back stage writes results to it.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file.sv | 77 +++++++
 tb/tb_reg_file.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared hxd32 core constants and types for the integer register file.
// The core, the register file and its bench all import this package.
package reg_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    // x0 is architecturally zero: never stored, always reads zero.
    function automatic logic is_x0(input reg_idx_t idx);
        return (idx == {REG_ADDR_W{1'b0}});
    endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// hxd32 RV32I integer register file: x1..x31 in flops, x0 hardwired to zero,
// two combinational read ports and one write port, asynchronous active-low clear.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rd_wr_en_i,
    input  logic [4:0]        rd_wr_addr_i,
    input  logic [XLEN_P-1:0] rd_wr_data_i,
    input  logic [4:0]        rs1_rd_addr_i,
    input  logic [4:0]        rs2_rd_addr_i,
    output logic [XLEN_P-1:0] rs1_rd_data_o,
    output logic [XLEN_P-1:0] rs2_rd_data_o
);

    logic [XLEN_P-1:0]   regs_q [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] wr_sel_d;

    // One-hot write select; x0 has no entry so writes to it fall away.
    always_comb begin
        wr_sel_d = {(NUM_REGS-1){1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rd_wr_en_i && (rd_wr_addr_i == REG_ADDR_W'(i))) begin
                wr_sel_d[i] = 1'b1;
            end else begin
                wr_sel_d[i] = 1'b0;
            end
        end
    end

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
        // Storage entry with asynchronous clear; reset beats a coincident write.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                regs_q[g] <= {XLEN_P{1'b0}};
            end else if (wr_sel_d[g]) begin
                regs_q[g] <= rd_wr_data_i;
            end
        end
    end

    // Read port 1 mux: no write bypass, x0 returns zero.
    always_comb begin
        rs1_rd_data_o = {XLEN_P{1'b0}};
        if (!is_x0(rs1_rd_addr_i)) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rs1_rd_addr_i == REG_ADDR_W'(i)) begin
                    rs1_rd_data_o = regs_q[i];
                end else begin
                    rs1_rd_data_o = rs1_rd_data_o;
                end
            end
        end else begin
            rs1_rd_data_o = {XLEN_P{1'b0}};
        end
    end

    // Read port 2 mux, independent of port 1.
    always_comb begin
        rs2_rd_data_o = {XLEN_P{1'b0}};
        if (!is_x0(rs2_rd_addr_i)) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rs2_rd_addr_i == REG_ADDR_W'(i)) begin
                    rs2_rd_data_o = regs_q[i];
                end else begin
                    rs2_rd_data_o = rs2_rd_data_o;
                end
            end
        end else begin
            rs2_rd_data_o = {XLEN_P{1'b0}};
        end
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed tables, corner sequences and a
// randomized run against an array-based reference model.
module tb_reg_file;
    import reg_file_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] model [NUM_REGS];

    typedef struct {
        logic [4:0]      a1;
        logic [4:0]      a2;
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
    } vec_t;

    vec_t vecs [NUM_REGS];

    reg_file dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .rd_wr_en_i    (wr_en),
        .rd_wr_addr_i  (wr_addr),
        .rd_wr_data_i  (wr_data),
        .rs1_rd_addr_i (rs1_addr),
        .rs2_rd_addr_i (rs2_addr),
        .rs1_rd_data_o (rs1_data),
        .rs2_rd_data_o (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] model_rd(input logic [4:0] a);
        return (a == 5'd0) ? {XLEN{1'b0}} : model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) model[i] = {XLEN{1'b0}};
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < NUM_REGS; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(NUM_REGS - 1 - i);
            #1;
            check({name, "_rs1"}, rs1_data, {XLEN{1'b0}});
            check({name, "_rs2"}, rs2_data, {XLEN{1'b0}});
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [XLEN-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        if (a != 5'd0) model[a] = d;
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = {XLEN{1'b0}};
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        model_clear();

        // Fill-phase read table, expectations straight from "x_i holds i+16, x0 is 0".
        for (int i = 0; i < NUM_REGS; i++) begin
            vecs[i].a1 = 5'(i);
            vecs[i].a2 = 5'((i + 16) % 32);
            vecs[i].e1 = (i == 0) ? 32'd0 : 32'(i + 16);
            vecs[i].e2 = (((i + 16) % 32) == 0) ? 32'd0 : 32'(((i + 16) % 32) + 16);
        end

        // Reset held: every address reads zero, even across clock edges with write enabled.
        check_all_zero("reset_sweep");
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rs1_addr = 5'd3; #1;
        check("reset_wins_edge", rs1_data, 32'd0);
        wr_en = 1'b0;

        @(negedge clk);
        rst_n = 1'b1;

        // Fill x0..x31 with i+16, then read back through the table.
        for (int i = 0; i < NUM_REGS; i++) write_reg(5'(i), 32'(i + 16));
        for (int i = 0; i < NUM_REGS; i++) begin
            rs1_addr = vecs[i].a1;
            rs2_addr = vecs[i].a2;
            #1;
            check($sformatf("fill_rs1_x%0d", vecs[i].a1), rs1_data, vecs[i].e1);
            check($sformatf("fill_rs2_x%0d", vecs[i].a2), rs2_data, vecs[i].e2);
        end

        // Enable low: x5 must hold 21 across several edges.
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        repeat (3) @(posedge clk);
        #1;
        check("en_gate_rs1", rs1_data, 32'd21);
        check("en_gate_rs2", rs2_data, 32'd21);

        // Same-cycle read/write of x7: old value before the edge, new value after.
        @(negedge clk);
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
        #1;
        check("rw_before_rs1", rs1_data, 32'd23);
        check("rw_before_rs2", rs2_data, 32'd23);
        @(posedge clk); #1;
        model[7] = 32'h1234_5678;
        check("rw_after_rs1", rs1_data, 32'h1234_5678);
        check("rw_after_rs2", rs2_data, 32'h1234_5678);
        wr_en = 1'b0;

        // Write to x0 is discarded.
        write_reg(5'd0, 32'hFFFF_FFFF);
        rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
        check("x0_write_rs1", rs1_data, 32'd0);
        check("x0_write_rs2", rs2_data, 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            wr_en    = ($urandom_range(0, 3) != 0);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            rs1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            #1;
            check("rand_pre_rs1", rs1_data, model_rd(rs1_addr));
            check("rand_pre_rs2", rs2_data, model_rd(rs2_addr));
            @(posedge clk);
            if (wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
            #1;
            check("rand_post_rs1", rs1_data, model_rd(rs1_addr));
            check("rand_post_rs2", rs2_data, model_rd(rs2_addr));
        end
        wr_en = 1'b0;

        // Mid-cycle reset: outputs drop before the next edge.
        write_reg(5'd9, 32'hA5A5_5A5A);
        rs1_addr = 5'd9; rs2_addr = 5'd7; #1;
        check("pre_reset_rs1", rs1_data, 32'hA5A5_5A5A);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_rs1", rs1_data, 32'd0);
        check("mid_reset_rs2", rs2_data, 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("post_reset_sweep");

        // First edge after release accepts a write.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h0BAD_CAFE;
        rs1_addr = 5'd31; rs2_addr = 5'd30;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("first_write_rs1", rs1_data, 32'h0BAD_CAFE);
        check("first_write_rs2", rs2_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_reg_file
